prio_encoder: RTL and testbench



---
 rtl/prio_encoder.sv | 126 ++++++++++++
 tb/tb_prio_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder.sv
// Sequential N-to-W priority encoder with a valid/ack handshake.
// Rising edges on req_i are captured into a pending register. The highest-priority pending
// index is presented on code_o with valid_o, and that bit is cleared when it is acknowledged.
// Optional build macro PRIO_ENC_ROUND_ROBIN_EN enables a rotating priority pointer in place of
// fixed highest-index priority.
module prio_encoder #(
  parameter int unsigned W = 3,
  parameter int unsigned N = 8  // must equal 2**W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         ack_i,
  output logic [W-1:0] code_o,
  output logic         valid_o,
  output logic [N-1:0] pend_o,
  output logic         ovf_o
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   req_q;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   rise;
  logic [N-1:0]   clr;
  logic [W-1:0]   code_q, code_d;
  logic [W-1:0]   sel;
  logic           ovf_q, ovf_d;
  logic           grant;

  // A grant is accepted only while a code is being presented.
  assign grant = (state_q == StPresent) & ack_i;
  assign rise  = req_i & ~req_q;

  // Clear vector and pending update; a same-cycle set beats the clear.
  always_comb begin
    clr = '0;
    if (grant) clr[code_q] = 1'b1;
    pend_d = (pend_q & ~clr) | rise;
    ovf_d  = |(rise & pend_q & ~clr);
  end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx;
  logic         found;

  // Search downward from ptr_q with wrap-around; the first pending index wins.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr_q - W'(i);
      if (!found && pend_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // After granting code c the search restarts just below c.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = code_q - W'(1);
  end

  // Priority pointer register; reset value makes the first grant behave as fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed priority: the highest set index wins (later iterations overwrite earlier ones).
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_q[i]) sel = W'(i);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pend_q != '0) state_d = StPresent;
      StPresent: if (ack_i)        state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  // FSM output logic: latch a new code only when leaving idle; otherwise hold it.
  always_comb begin
    code_d = code_q;
    if (state_q == StIdle && pend_q != '0) code_d = sel;
  end

  // Datapath registers: edge detector, pending bits, code and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      pend_q <= '0;
      code_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      req_q  <= req_i;
      pend_q <= pend_d;
      code_q <= code_d;
      ovf_q  <= ovf_d;
    end
  end

  assign code_o  = code_q;
  assign valid_o = (state_q == StPresent);
  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_prio_encoder.sv
// Bench for prio_encoder: reset checks, a per-cycle vector table, and a grant-order scoreboard
// fed when an acknowledge is driven and drained by a monitor on accepted grants.
module tb_prio_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] r;
    logic       a;
    logic       v;
    logic [2:0] c;
    logic [7:0] p;
    logic       o;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] sb[$];

  prio_encoder #(.W(3), .N(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .ack_i  (ack),
    .code_o (code),
    .valid_o(valid),
    .pend_o (pend),
    .ovf_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic vec(input logic [7:0] r, input logic a, input logic v, input logic [2:0] c,
                     input logic [7:0] p, input logic o);
    vec_t t;
    t.r = r; t.a = a; t.v = v; t.c = c; t.p = p; t.o = o;
    vecs.push_back(t);
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic [7:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted grant must match the next expected code.
  always @(negedge clk) begin
    if (rst_n && valid && ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_order: unexpected grant code %0d", code);
      end else begin
        check("grant_order", 32'(code), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    logic       prev_v;
    logic [2:0] prev_c;
    int         n;

    // Reset held with all requests high.
    rst_n = 1'b0;
    req   = 8'hFF;
    ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_code",  32'(code),  0);
    check("rst_pend",  32'(pend),  0);
    check("rst_ovf",   32'(ovf),   0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_pend_e1",  32'(pend),  32'hFF);
    check("rel_valid_e1", 32'(valid), 0);
    @(posedge clk); #1;
    check("rel_valid_e2", 32'(valid), 1);
    check("rel_code_e2",  32'(code),  7);
    // Asynchronous reset mid-handshake.
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 0);
    check("arst_code",  32'(code),  0);
    check("arst_pend",  32'(pend),  0);
    check("arst_ovf",   32'(ovf),   0);
    req = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // req, ack, exp valid, exp code, exp pend, exp ovf (outputs after the edge)
    vec(8'h00, 0, 0, 0, 8'h00, 0);
    vec(8'h04, 0, 0, 0, 8'h04, 0);  // single event
    vec(8'h04, 0, 1, 2, 8'h04, 0);
    vec(8'h04, 1, 0, 2, 8'h00, 0);
    vec(8'h04, 1, 0, 2, 8'h00, 0);  // ack while idle ignored
    vec(8'h00, 1, 0, 2, 8'h00, 0);
    vec(8'h24, 0, 0, 2, 8'h24, 0);  // two rise together
    vec(8'h24, 0, 1, 5, 8'h24, 0);
    vec(8'h24, 1, 0, 5, 8'h04, 0);
    vec(8'h24, 0, 1, 2, 8'h04, 0);
    vec(8'h24, 1, 0, 2, 8'h00, 0);
    vec(8'h00, 0, 0, 2, 8'h00, 0);
    vec(8'h02, 0, 0, 2, 8'h02, 0);  // no preemption
    vec(8'h02, 0, 1, 1, 8'h02, 0);
    vec(8'h42, 0, 1, 1, 8'h42, 0);
    vec(8'h42, 0, 1, 1, 8'h42, 0);
    vec(8'h42, 0, 1, 1, 8'h42, 0);
    vec(8'h42, 0, 1, 1, 8'h42, 0);
    vec(8'h42, 0, 1, 1, 8'h42, 0);
    vec(8'h42, 1, 0, 1, 8'h40, 0);
    vec(8'h42, 0, 1, 6, 8'h40, 0);
    vec(8'h00, 1, 0, 6, 8'h00, 0);
    vec(8'h08, 0, 0, 6, 8'h08, 0);  // overflow
    vec(8'h08, 0, 1, 3, 8'h08, 0);
    vec(8'h00, 0, 1, 3, 8'h08, 0);
    vec(8'h08, 0, 1, 3, 8'h08, 1);
    vec(8'h08, 0, 1, 3, 8'h08, 0);
    vec(8'h00, 0, 1, 3, 8'h08, 0);  // collision with ack
    vec(8'h08, 1, 0, 3, 8'h08, 0);
    vec(8'h08, 0, 1, 3, 8'h08, 0);
    vec(8'h00, 1, 0, 3, 8'h00, 0);
    vec(8'h00, 0, 0, 3, 8'h00, 0);

    prev_v = 1'b0;
    prev_c = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].a && prev_v) sb.push_back(prev_c);
      step(vecs[i].r, vecs[i].a);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].v));
      check($sformatf("vec%0d_code", i),  32'(code),  32'(vecs[i].c));
      check($sformatf("vec%0d_pend", i),  32'(pend),  32'(vecs[i].p));
      check($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].o));
      prev_v = vecs[i].v;
      prev_c = vecs[i].c;
    end
    check("sb_drain_table", 32'(sb.size()), 0);

    // Priority mode: bits 7 and 0 retriggered on every ack, four grants.
    rst_n = 1'b0;
    req   = 8'h00;
    ack   = 1'b0;
    #2 rst_n = 1'b1;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    sb.push_back(3'd7); sb.push_back(3'd0); sb.push_back(3'd7); sb.push_back(3'd0);
`else
    sb.push_back(3'd7); sb.push_back(3'd7); sb.push_back(3'd7); sb.push_back(3'd7);
`endif
    step(8'h81, 1'b0);
    for (int g = 0; g < 4; g++) begin
      step(8'h00, 1'b0);
      n = 0;
      while (!valid && n < 8) begin
        step(8'h00, 1'b0);
        n++;
      end
      check($sformatf("prio_valid%0d", g), 32'(valid), 1);
      step(8'h81, 1'b1);
    end
    step(8'h00, 1'b0);
    check("sb_drain_prio", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
